// File: rtl/code_unpacker_if.sv
// Handshake and data bundle between the packed-word source / code parser and the unpacker.
// master drives words and consume requests; slave is the unpacker itself.
interface code_unpacker_if #(
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             ena_in;
  logic             rdy_out;
  logic [WIDTH-1:0] word;
  logic             flush;
  logic             take;
  logic [CW-1:0]    consume;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    avail;
  logic             ena_out;

  modport master (
    output ena_in, word, flush, take, consume,
    input  rdy_out, out, avail, ena_out
  );

  modport slave (
    input  ena_in, word, flush, take, consume,
    output rdy_out, out, avail, ena_out
  );
endinterface

// File: rtl/code_unpacker.sv
// Bit-stream unpacker: buffers up to two packed words and presents the next unconsumed
// bits MSB-aligned so the code parser can consume a variable number of bits per cycle.
module code_unpacker #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  code_unpacker_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int NW = $clog2(WIDTH) + 2;

  logic [2*WIDTH-1:0] bit_buf;
  logic [NW-1:0]      count;

  logic [NW-1:0]      c;
  logic [NW-1:0]      r;
  logic               accept;
  logic [2*WIDTH-1:0] incoming;
  logic [2*WIDTH-1:0] buf_nxt;
  logic [NW-1:0]      count_nxt;

  // An over-consume is a protocol error; clamping keeps count from wrapping.
  function automatic logic [NW-1:0] clamp_consume(input logic [CW-1:0] req,
                                                  input logic [NW-1:0] lim);
    logic [NW-1:0] ext;
    ext = NW'(req);
    return (ext > lim) ? lim : ext;
  endfunction

  always_comb begin
    bus.rdy_out = !rst && !bus.flush && (count <= NW'(WIDTH));
    accept      = bus.ena_in && bus.rdy_out;
    c           = bus.take ? clamp_consume(bus.consume, count) : '0;
    r           = count - c;
    // Word placed directly behind the r surviving bits; equals word << (WIDTH - r)
    // for r <= WIDTH without ever forming a negative shift amount.
    incoming    = {bus.word, {WIDTH{1'b0}}} >> r;
    buf_nxt     = (bit_buf << c) | (accept ? incoming : '0);
    count_nxt   = r + (accept ? NW'(WIDTH) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      bit_buf <= '0;
      count   <= '0;
    end else begin
      bit_buf <= buf_nxt;
      count   <= count_nxt;
    end
  end

  assign bus.out     = bit_buf[2*WIDTH-1:WIDTH];
  assign bus.avail   = (count > NW'(WIDTH)) ? CW'(WIDTH) : count[CW-1:0];
  assign bus.ena_out = (count != '0);
endmodule

// File: tb/tb_code_unpacker.sv
// Bench for code_unpacker (WIDTH=16): bit-queue reference model checked every cycle,
// directed boundary scenarios with literal expectations, and a randomized stream run.
module tb_code_unpacker;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  code_unpacker_if #(.WIDTH(W)) bus();
  code_unpacker #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  bit q[$];
  bit in_log[$];
  bit out_log[$];
  bit chk_on   = 1'b0;
  int words_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_out();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++)
      if (i < q.size()) v[W-1-i] = q[i];
    return v;
  endfunction

  function automatic int exp_avail();
    return (q.size() < W) ? q.size() : W;
  endfunction

  // Applied at the rising edge with the inputs the DUT sampled there.
  task automatic model_step();
    int n;
    bit b;
    if (rst || bus.flush) begin
      q.delete();
    end else begin
      bit acc;
      acc = bus.ena_in && (q.size() <= W);
      n = 0;
      if (bus.take) begin
        n = int'(bus.consume);
        if (n > q.size()) begin
          checks++;
          failures++;
          $display("FAIL overconsume: got %0d expected <= %0d", n, q.size());
          n = q.size();
        end
      end
      repeat (n) out_log.push_back(q.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          b = bus.word[W-1-i];
          q.push_back(b);
          in_log.push_back(b);
        end
        words_acc++;
      end
    end
  endtask

  task automatic step(input logic ena, input logic [W-1:0] w, input logic fl,
                      input logic tk, input int cons);
    bus.ena_in  = ena;
    bus.word    = w;
    bus.flush   = fl;
    bus.take    = tk;
    bus.consume = 5'(cons);
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("rdy_out", {31'd0, bus.rdy_out}, {31'd0, (!rst && !bus.flush && q.size() <= W)});
      check("avail",   {27'd0, bus.avail}, exp_avail());
      check("out",     {16'd0, bus.out},   {16'd0, exp_out()});
      check("ena_out", {31'd0, bus.ena_out}, {31'd0, (q.size() != 0)});
    end
  end

  initial begin
    int cycles;
    int lim;
    int mism;
    rst = 1'b1;
    bus.ena_in = 1'b0; bus.word = '0; bus.flush = 1'b0; bus.take = 1'b0; bus.consume = '0;
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    rst = 1'b0;
    chk_on = 1'b1;
    step(0, 16'h0, 0, 0, 0);
    check("reset_avail", {27'd0, bus.avail}, 0);
    check("reset_out", {16'd0, bus.out}, 0);
    check("reset_rdy", {31'd0, bus.rdy_out}, 1);

    // Reset mid-stream with 20 bits buffered
    step(1, 16'hC3A5, 0, 0, 0);
    step(1, 16'h5A5A, 0, 1, 12);
    check("mid_avail", {27'd0, bus.avail}, 16);
    rst = 1'b1;
    step(1, 16'hFFFF, 0, 0, 0);
    check("rst_avail", {27'd0, bus.avail}, 0);
    check("rst_out", {16'd0, bus.out}, 0);
    check("rst_rdy_low", {31'd0, bus.rdy_out}, 0);
    rst = 1'b0;
    step(0, 16'h0, 0, 0, 0);
    check("rst_word_dropped", {27'd0, bus.avail}, 0);
    check("rst_rdy_high", {31'd0, bus.rdy_out}, 1);

    // Inverse of the packer example
    step(0, 16'h0, 1, 0, 0);
    step(1, 16'h8030, 0, 0, 0);
    step(1, 16'h4000, 0, 0, 0);
    check("pk_code11", {21'd0, bus.out[15:5]}, 32'b10000000001);
    step(0, 16'h0, 0, 1, 11);
    check("pk_code7", {25'd0, bus.out[15:9]}, 32'b1000001);
    step(0, 16'h0, 0, 1, 7);
    check("pk_avail", {27'd0, bus.avail}, 14);
    check("pk_out", {16'd0, bus.out}, 0);

    // Full-buffer backpressure with a held word
    step(0, 16'h0, 1, 0, 0);
    step(1, 16'h1111, 0, 0, 0);
    step(1, 16'h2222, 0, 0, 0);
    check("bp_full_rdy", {31'd0, bus.rdy_out}, 0);
    step(1, 16'h3C3C, 0, 1, 1);
    check("bp_31_rdy", {31'd0, bus.rdy_out}, 0);
    step(1, 16'h3C3C, 0, 1, 15);
    check("bp_16_rdy", {31'd0, bus.rdy_out}, 1);
    check("bp_out_b", {16'd0, bus.out}, 32'h2222);
    step(1, 16'h3C3C, 0, 0, 0);
    check("bp_accepted", {27'd0, bus.avail}, 16);
    step(0, 16'h0, 0, 1, 16);
    check("bp_out_c", {16'd0, bus.out}, 32'h3C3C);

    // Concurrent accept and take
    step(0, 16'h0, 1, 0, 0);
    step(1, 16'h0016, 0, 0, 0);
    step(0, 16'h0, 0, 1, 11);
    check("cc_avail5", {27'd0, bus.avail}, 5);
    check("cc_top5", {27'd0, bus.out[15:11]}, 32'b10110);
    step(1, 16'hFFFF, 0, 1, 3);
    check("cc_avail", {27'd0, bus.avail}, 16);
    check("cc_out", {16'd0, bus.out}, 32'hBFFF);

    // Flush beats take and accept
    step(0, 16'h0, 1, 0, 0);
    step(1, 16'h1234, 0, 0, 0);
    step(0, 16'h0, 0, 1, 7);
    check("fl_avail9", {27'd0, bus.avail}, 9);
    step(1, 16'hAAAA, 1, 1, 4);
    check("fl_avail0", {27'd0, bus.avail}, 0);
    step(1, 16'h5A5A, 0, 0, 0);
    check("fl_out", {16'd0, bus.out}, 32'h5A5A);
    check("fl_avail", {27'd0, bus.avail}, 16);

    // Randomized stream with legal consume amounts
    step(0, 16'h0, 1, 0, 0);
    in_log.delete();
    out_log.delete();
    words_acc = 0;
    cycles = 0;
    while (words_acc < 64 && cycles < 2000) begin
      lim = (q.size() < W) ? q.size() : W;
      step(($urandom % 4) != 0, 16'($urandom), 0, ($urandom % 4) != 0,
           int'($urandom_range(0, lim)));
      cycles++;
    end
    if (cycles >= 2000) begin
      failures++;
      checks++;
      $display("FAIL rand_timeout: got %0d words expected 64", words_acc);
    end
    while (q.size() > 0 && cycles < 4000) begin
      lim = (q.size() < W) ? q.size() : W;
      step(0, 16'h0, 0, 1, lim);
      cycles++;
    end
    check("rand_words", words_acc, 64);
    check("rand_len", out_log.size(), in_log.size());
    mism = 0;
    for (int i = 0; i < in_log.size() && i < out_log.size(); i++)
      if (in_log[i] != out_log[i]) mism++;
    check("rand_bits", mism, 0);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
